eq_adapt_ctrl: RTL and testbench
================================

# eq_adapt_ctrl

Adaptation controller for the LMS equalizer loop around the QPSK slicer with error output. It takes the frame-delimited equalizer output, slicer error and known training bits, and selects the error that drives the tap update: reference-based in training, slicer-based (decision-directed) once converged. It also sets the step-size shift and gates tap updates. A windowed mean-|error| monitor switches modes, and switches happen only at frame boundaries.

## Interface
- W, 16, sample/error width (signed, Q2.14)
- AMP, 16'sd11585, ideal QPSK amplitude (must equal slicer AMP)
- LOG2_WIN, 8, metric window = 2^LOG2_WIN symbols
- TH_LOCK, 17'd1200, window mean below this counts as a "good" window
- TH_UNLOCK, 17'd3000, window mean above this in DD forces retrain
- LOCK_CNT, 2, consecutive good windows needed to enter DD
- MU_TRAIN, 4'd4, step-size shift in TRAIN
- MU_DD, 4'd7, step-size shift in DD

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_valid / i_first / i_last  in  1 each  symbol strobe and frame delimiters (slicer-aligned)
- i_y_re, i_y_im  in  W  equalizer output, signed
- i_err_re, i_err_im  in  W  slicer error d−y, signed
- i_ref_bI, i_ref_bQ  in  1 each  training bits, 1 = negative, aligned with i_y
- i_freeze  in  1  forces o_upd_en=0; metric keeps running
- o_valid / o_first / o_last  out  1 each  registered copies of the input strobes
- o_err_re, o_err_im  out  W  selected error, signed
- o_upd_en  out  1  tap-update enable
- o_mu_shift  out  4  step-size right-shift
- o_mode  out  2  0=IDLE, 1=TRAIN, 2=DD
- o_locked  out  1  high while in DD
- o_metric  out  W+1  last completed window mean, unsigned

## Operation
- FSM, 3 states:
  - IDLE: go to TRAIN on i_valid & i_first. That symbol is already processed as TRAIN.
  - TRAIN: error = ref − y, with ref_re = i_ref_bI ? −AMP : AMP (same for im). Computed in W+1 bits, saturated to W.
  - DD: error = i_err passed through.
- Metric: per valid symbol, add |e_re|+|e_im| of the selected error.
  - abs saturates −2^(W−1) to 2^(W−1)−1.
  - Accumulator is W+1+LOG2_WIN bits.
  - At window end: mean = acc >> LOG2_WIN, latched to o_metric. Accumulator and window counter are then cleared.
- Lock logic:
  - In TRAIN, each window with mean < TH_LOCK increments good_cnt; any other window clears it.
  - When good_cnt reaches LOCK_CNT, set pend_dd.
  - In DD, a window with mean > TH_UNLOCK sets pend_train.
- Pending switches apply on the next i_valid & i_first. That symbol uses the new mode.
  - Applying a switch clears the pend flags, good_cnt, accumulator and window counter.
- o_upd_en = output valid & (mode ≠ IDLE) & ~i_freeze, with i_freeze sampled with the symbol.
- o_mu_shift = MU_TRAIN in TRAIN/IDLE, MU_DD in DD.

## Timing
- Latency is 1 cycle, input symbol to all outputs.
- Outputs are registered. o_valid/o_first/o_last pulse for one cycle per input valid.
- Reset values: mode=IDLE, all strobes 0, errors 0, o_metric 0, o_mu_shift=MU_TRAIN, o_locked 0, all internal counters and flags 0.
- Reset asserted mid-frame clears everything immediately; restart needs a new i_first.
- Window end coinciding with i_first: that symbol's mode was already chosen. The resulting pend flag acts at the next i_first.
- i_first without a prior i_last is still a valid boundary.
- i_valid low: no state changes and o_valid=0. Other data outputs hold.
- Windows span frame boundaries freely.

## Structure
- Package eq_ctrl_pkg holds:
  - mode localparams (MODE_IDLE/TRAIN/DD)
  - sat_w and abs_sat functions
  - the default AMP
- Sub-module err_metric_acc holds the abs, accumulator, window counter and mean output, with a clear input. It pulses a win_done strobe with the mean.
- Estimated size: ~250 RTL lines.

## Test plan
- Reset, then frame with i_first, y=(11585, −11585), ref bits (0, 1): o_mode=1, error (0, 0), o_upd_en=1 one cycle later, o_mu_shift=4.
- TRAIN with |e|sum=800 per symbol for 2 windows (512 symbols): o_metric=800, pend_dd set. The next i_first shows o_mode=2, o_locked=1, o_mu_shift=7, o_err = i_err.
- DD with error sum 4000 per symbol for one window: o_metric=4000. The next i_first returns o_mode=1 and good_cnt=0.
- Saturation: y_re=32767, ref_bI=1 gives o_err_re=−32768. err_re=−32768 contributes 32767 to the metric.
- i_freeze=1 during TRAIN: o_upd_en=0 while o_valid=1, and the metric still updates.
- Async rst asserted mid-window in DD: all outputs go to reset values without a clock edge. Symbols without i_first keep the block in IDLE.

Source files
------------

// File: rtl/eq_ctrl_pkg.sv
// Shared types and saturating helpers for the equalizer adaptation controller.
package eq_ctrl_pkg;

    localparam int unsigned              EQ_W        = 16;
    localparam logic signed [EQ_W-1:0]   AMP_DEFAULT = 16'sd11585;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_TRAIN = 2'd1,
        MODE_DD    = 2'd2
    } mode_t;

    function automatic logic signed [EQ_W-1:0] sat_w(input logic signed [EQ_W:0] x);
        if (x[EQ_W] != x[EQ_W-1])
            return x[EQ_W] ? {1'b1, {(EQ_W-1){1'b0}}} : {1'b0, {(EQ_W-1){1'b1}}};
        return x[EQ_W-1:0];
    endfunction

    // The most negative code has no positive twin, so it maps to full scale.
    function automatic logic [EQ_W-1:0] abs_sat(input logic signed [EQ_W-1:0] x);
        if (x == {1'b1, {(EQ_W-1){1'b0}}})
            return {1'b0, {(EQ_W-1){1'b1}}};
        if (x[EQ_W-1])
            return -x;
        return x;
    endfunction

endpackage

// File: rtl/err_metric_acc.sv
// Windowed mean-|error| accumulator; win_done/win_mean are valid in the cycle
// the last symbol of a window is presented, o_metric holds the latest mean.
module err_metric_acc
    import eq_ctrl_pkg::*;
#(
    parameter int unsigned W        = EQ_W,
    parameter int unsigned LOG2_WIN = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clr,
    input  logic signed [W-1:0] e_re,
    input  logic signed [W-1:0] e_im,
    output logic                win_done,
    output logic [W:0]          win_mean,
    output logic [W:0]          metric
);

    localparam int unsigned AW = W + 1 + LOG2_WIN;

    logic [AW-1:0]       acc, acc_nxt;
    logic [LOG2_WIN-1:0] cnt;
    logic [W-1:0]        mag_re, mag_im;
    logic [W:0]          mag_sum;

    always_comb begin
        mag_re   = abs_sat(e_re);
        mag_im   = abs_sat(e_im);
        mag_sum  = {1'b0, mag_re} + {1'b0, mag_im};
        acc_nxt  = acc + AW'(mag_sum);
        win_done = en && !clr && (cnt == '1);
        win_mean = acc_nxt[AW-1:LOG2_WIN];
    end

    // A clear that coincides with a symbol starts the new window with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            metric <= '0;
        end else if (clr) begin
            acc <= en ? AW'(mag_sum) : '0;
            cnt <= en ? LOG2_WIN'(1) : '0;
        end else if (en) begin
            if (cnt == '1) begin
                acc    <= '0;
                cnt    <= '0;
                metric <= win_mean;
            end else begin
                acc <= acc_nxt;
                cnt <= cnt + LOG2_WIN'(1);
            end
        end
    end

endmodule

// File: rtl/eq_adapt_ctrl.sv
// LMS adaptation controller: selects training or decision-directed error,
// step size and update gating, switching modes only at frame starts.
module eq_adapt_ctrl
    import eq_ctrl_pkg::*;
#(
    parameter int unsigned         W         = EQ_W,
    parameter logic signed [W-1:0] AMP       = AMP_DEFAULT,
    parameter int unsigned         LOG2_WIN  = 8,
    parameter logic [W:0]          TH_LOCK   = 17'd1200,
    parameter logic [W:0]          TH_UNLOCK = 17'd3000,
    parameter int unsigned         LOCK_CNT  = 2,
    parameter logic [3:0]          MU_TRAIN  = 4'd4,
    parameter logic [3:0]          MU_DD     = 4'd7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    input  logic                i_first,
    input  logic                i_last,
    input  logic signed [W-1:0] i_y_re,
    input  logic signed [W-1:0] i_y_im,
    input  logic signed [W-1:0] i_err_re,
    input  logic signed [W-1:0] i_err_im,
    input  logic                i_ref_bI,
    input  logic                i_ref_bQ,
    input  logic                i_freeze,
    output logic                o_valid,
    output logic                o_first,
    output logic                o_last,
    output logic signed [W-1:0] o_err_re,
    output logic signed [W-1:0] o_err_im,
    output logic                o_upd_en,
    output logic [3:0]          o_mu_shift,
    output logic [1:0]          o_mode,
    output logic                o_locked,
    output logic [W:0]          o_metric
);

    mode_t               mode, mode_nxt, sym_mode;
    logic                pend_dd, pend_dd_nxt, pend_train, pend_train_nxt;
    logic [3:0]          good_cnt, good_cnt_nxt;
    logic                start, mode_switch, acc_en;
    logic signed [W:0]   amp_x, ref_re, ref_im, diff_re, diff_im;
    logic signed [W-1:0] sel_re, sel_im;
    logic                win_done;
    logic [W:0]          win_mean;

    err_metric_acc #(.W(W), .LOG2_WIN(LOG2_WIN)) u_metric (
        .clk      (clk),
        .rst      (rst),
        .en       (acc_en),
        .clr      (mode_switch),
        .e_re     (sel_re),
        .e_im     (sel_im),
        .win_done (win_done),
        .win_mean (win_mean),
        .metric   (o_metric)
    );

    always_comb begin
        start    = i_valid & i_first;
        sym_mode = mode;
        case (mode)
            MODE_IDLE:  if (start)               sym_mode = MODE_TRAIN;
            MODE_TRAIN: if (start && pend_dd)    sym_mode = MODE_DD;
            MODE_DD:    if (start && pend_train) sym_mode = MODE_TRAIN;
            default:                             sym_mode = MODE_IDLE;
        endcase
        mode_switch = (sym_mode != mode);
        acc_en      = i_valid && (sym_mode != MODE_IDLE);

        amp_x   = (W+1)'(AMP);
        ref_re  = i_ref_bI ? -amp_x : amp_x;
        ref_im  = i_ref_bQ ? -amp_x : amp_x;
        diff_re = ref_re - (W+1)'(i_y_re);
        diff_im = ref_im - (W+1)'(i_y_im);
        case (sym_mode)
            MODE_TRAIN: begin sel_re = sat_w(diff_re); sel_im = sat_w(diff_im); end
            MODE_DD:    begin sel_re = i_err_re;       sel_im = i_err_im;       end
            default:    begin sel_re = '0;             sel_im = '0;             end
        endcase

        mode_nxt       = sym_mode;
        pend_dd_nxt    = mode_switch ? 1'b0 : pend_dd;
        pend_train_nxt = mode_switch ? 1'b0 : pend_train;
        good_cnt_nxt   = mode_switch ? '0 : good_cnt;
        // A window closing on a frame-start symbol only arms the next boundary.
        if (win_done) begin
            if (sym_mode == MODE_TRAIN) begin
                if (win_mean < TH_LOCK) begin
                    if (good_cnt < 4'(LOCK_CNT))
                        good_cnt_nxt = good_cnt + 4'd1;
                    if (good_cnt + 4'd1 >= 4'(LOCK_CNT))
                        pend_dd_nxt = 1'b1;
                end else begin
                    good_cnt_nxt = '0;
                end
            end else if (sym_mode == MODE_DD && win_mean > TH_UNLOCK) begin
                pend_train_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode       <= MODE_IDLE;
            pend_dd    <= 1'b0;
            pend_train <= 1'b0;
            good_cnt   <= '0;
        end else begin
            mode       <= mode_nxt;
            pend_dd    <= pend_dd_nxt;
            pend_train <= pend_train_nxt;
            good_cnt   <= good_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid  <= 1'b0;
            o_first  <= 1'b0;
            o_last   <= 1'b0;
            o_upd_en <= 1'b0;
            o_err_re <= '0;
            o_err_im <= '0;
        end else begin
            o_valid  <= i_valid;
            o_first  <= i_valid & i_first;
            o_last   <= i_valid & i_last;
            o_upd_en <= acc_en & ~i_freeze;
            if (i_valid) begin
                o_err_re <= sel_re;
                o_err_im <= sel_im;
            end
        end
    end

    assign o_mode     = mode;
    assign o_locked   = (mode == MODE_DD);
    assign o_mu_shift = o_locked ? MU_DD : MU_TRAIN;

endmodule

// File: tb/tb_eq_adapt_ctrl.sv
// Self-checking bench for eq_adapt_ctrl: per-cycle comparison against a
// frame/window-level behavioural model plus hand-computed spot checks.
module tb_eq_adapt_ctrl;

    localparam int AMP       = 11585;
    localparam int WIN       = 256;
    localparam int TH_LOCK   = 1200;
    localparam int TH_UNLOCK = 3000;
    localparam int LOCK_CNT  = 2;

    logic               clk, rst;
    logic               i_valid, i_first, i_last, i_ref_bI, i_ref_bQ, i_freeze;
    logic signed [15:0] i_y_re, i_y_im, i_err_re, i_err_im;
    logic               o_valid, o_first, o_last, o_upd_en, o_locked;
    logic signed [15:0] o_err_re, o_err_im;
    logic [3:0]         o_mu_shift;
    logic [1:0]         o_mode;
    logic [16:0]        o_metric;

    int nvec = 0;
    int nmis = 0;

    eq_adapt_ctrl dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_first(i_first), .i_last(i_last),
        .i_y_re(i_y_re), .i_y_im(i_y_im),
        .i_err_re(i_err_re), .i_err_im(i_err_im),
        .i_ref_bI(i_ref_bI), .i_ref_bQ(i_ref_bQ), .i_freeze(i_freeze),
        .o_valid(o_valid), .o_first(o_first), .o_last(o_last),
        .o_err_re(o_err_re), .o_err_im(o_err_im),
        .o_upd_en(o_upd_en), .o_mu_shift(o_mu_shift),
        .o_mode(o_mode), .o_locked(o_locked), .o_metric(o_metric)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0/1/2, one "switch pending" flag, window sum.
    int     m_mode, m_good, m_n, m_metric;
    longint m_sum;
    bit     m_pend;
    int     x_err_re, x_err_im;
    bit     x_valid, x_first, x_last, x_upd;

    function automatic int clampw(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int mag(input int v);
        return (v < 0) ? ((-v > 32767) ? 32767 : -v) : v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pend = 0; m_good = 0; m_n = 0; m_sum = 0; m_metric = 0;
        x_err_re = 0; x_err_im = 0;
        x_valid = 0; x_first = 0; x_last = 0; x_upd = 0;
    endtask

    task automatic model_step();
        int target, er, ei, r_re, r_im;
        target = m_mode;
        if (i_first) begin
            if (m_mode == 0)  target = 1;
            else if (m_pend)  target = 3 - m_mode;
        end
        if (target != m_mode) begin
            m_mode = target; m_pend = 0; m_good = 0; m_sum = 0; m_n = 0;
        end
        x_valid = 1; x_first = i_first; x_last = i_last;
        x_upd   = (m_mode != 0) && !i_freeze;
        if (m_mode != 0) begin
            if (m_mode == 1) begin
                r_re = i_ref_bI ? -AMP : AMP;
                r_im = i_ref_bQ ? -AMP : AMP;
                er = clampw(r_re - int'(i_y_re));
                ei = clampw(r_im - int'(i_y_im));
            end else begin
                er = int'(i_err_re);
                ei = int'(i_err_im);
            end
            x_err_re = er; x_err_im = ei;
            m_sum += longint'(mag(er) + mag(ei));
            m_n++;
            if (m_n == WIN) begin
                m_metric = int'(m_sum / WIN);
                m_sum = 0; m_n = 0;
                if (m_mode == 1) begin
                    if (m_metric < TH_LOCK) begin
                        m_good++;
                        if (m_good >= LOCK_CNT) m_pend = 1;
                    end else begin
                        m_good = 0;
                    end
                end else if (m_metric > TH_UNLOCK) begin
                    m_pend = 1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) model_reset();
        else if (i_valid) model_step();
        else begin
            x_valid = 0; x_first = 0; x_last = 0; x_upd = 0;
        end
        #1;
        chk("o_valid",    o_valid,    x_valid);
        chk("o_first",    o_first,    x_first);
        chk("o_last",     o_last,     x_last);
        chk("o_upd_en",   o_upd_en,   x_upd);
        chk("o_err_re",   o_err_re,   x_err_re);
        chk("o_err_im",   o_err_im,   x_err_im);
        chk("o_mode",     o_mode,     m_mode);
        chk("o_locked",   o_locked,   m_mode == 2);
        chk("o_mu_shift", o_mu_shift, (m_mode == 2) ? 7 : 4);
        chk("o_metric",   o_metric,   m_metric);
    end

    task automatic sym(input bit v, input bit f, input bit l,
                       input int yre, input int yim, input int ere, input int eim,
                       input bit bi, input bit bq, input bit frz);
        i_valid = v; i_first = f; i_last = l;
        i_y_re = 16'(yre); i_y_im = 16'(yim);
        i_err_re = 16'(ere); i_err_im = 16'(eim);
        i_ref_bI = bi; i_ref_bQ = bq; i_freeze = frz;
        @(posedge clk); #2;
        i_valid = 0; i_first = 0; i_last = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    initial begin
        rst = 1; i_valid = 0; i_first = 0; i_last = 0;
        i_y_re = 0; i_y_im = 0; i_err_re = 0; i_err_im = 0;
        i_ref_bI = 0; i_ref_bQ = 0; i_freeze = 0;
        repeat (3) @(posedge clk);
        #2 rst = 0;
        chk("rst_mode", o_mode, 0);
        chk("rst_mu", o_mu_shift, 4);
        chk("rst_metric", o_metric, 0);

        repeat (3) sym(1, 0, 0, 100, 100, 5, 5, 0, 0, 0);
        chk("idle_mode", o_mode, 0);
        chk("idle_upd", o_upd_en, 0);

        // Training: first symbol exact, then |e| sum 800 per symbol.
        for (int k = 0; k < 512; k++) begin
            if (k == 0) begin
                sym(1, 1, 0, 11585, -11585, 0, 0, 0, 1, 0);
                chk("start_mode", o_mode, 1);
                chk("start_err_re", o_err_re, 0);
                chk("start_err_im", o_err_im, 0);
                chk("start_upd", o_upd_en, 1);
                chk("start_mu", o_mu_shift, 4);
            end else begin
                sym(1, (k % 64) == 0, (k % 64) == 63, 11185, -11185, 77, 77, 0, 1, 0);
            end
            if (k == 100) idle(2);
            if (k == 255) chk("win1_metric", o_metric, 796);
        end
        chk("win2_metric", o_metric, 800);
        chk("pre_dd_mode", o_mode, 1);

        // Decision-directed with a large error: expect retrain request.
        for (int k = 512; k < 768; k++) begin
            sym(1, (k % 64) == 0, (k % 64) == 63, 11585, 11585, 2500, -1500, 0, 0, 0);
            if (k == 512) begin
                chk("dd_mode", o_mode, 2);
                chk("dd_locked", o_locked, 1);
                chk("dd_mu", o_mu_shift, 7);
                chk("dd_err_re", o_err_re, 2500);
                chk("dd_err_im", o_err_im, -1500);
            end
        end
        chk("dd_metric", o_metric, 4000);

        // Back to training with a saturating reference difference.
        for (int k = 768; k < 1024; k++) begin
            sym(1, (k % 64) == 0, (k % 64) == 63, 32767, -11585, 0, 0, 1, 1, 0);
            if (k == 768) begin
                chk("retrain_mode", o_mode, 1);
                chk("sat_err_re", o_err_re, -32768);
                chk("sat_err_im", o_err_im, 0);
            end
        end
        chk("sat_metric", o_metric, 32767);

        // Frozen symbols still count towards the window.
        for (int k = 1024; k < 1536; k++) begin
            sym(1, (k % 64) == 0, (k % 64) == 63, 11185, -11185, 0, 0, 0, 1, k < 1040);
            if (k == 1024) begin
                chk("frz_upd", o_upd_en, 0);
                chk("frz_valid", o_valid, 1);
            end
            if (k == 1279) chk("frz_metric", o_metric, 800);
        end

        for (int k = 1536; k < 1560; k++) begin
            sym(1, (k % 64) == 0, (k % 64) == 63, 0, 0, 100, 100, 0, 0, 0);
            if (k == 1536) chk("relock_mode", o_mode, 2);
        end

        // Asynchronous reset mid-window, checked before any clock edge.
        rst = 1;
        #1;
        chk("arst_mode", o_mode, 0);
        chk("arst_locked", o_locked, 0);
        chk("arst_mu", o_mu_shift, 4);
        chk("arst_metric", o_metric, 0);
        chk("arst_valid", o_valid, 0);
        chk("arst_err_re", o_err_re, 0);
        @(posedge clk); @(posedge clk); #2 rst = 0;

        repeat (4) sym(1, 0, 0, 0, 0, 300, 300, 0, 0, 0);
        chk("post_rst_mode", o_mode, 0);
        chk("post_rst_upd", o_upd_en, 0);
        sym(1, 1, 0, 11585, 11585, 0, 0, 0, 0, 0);
        chk("restart_mode", o_mode, 1);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
